// File: rtl/mlkem_top_mont_reduce_pipe.sv
// mlkem_top_mont_reduce_pipe: 3-stage signed Montgomery reducer, r = a*2^-16 mod Q, valid/ready with full backpressure
module mlkem_top_mont_reduce_pipe #(
    parameter int DIN_WIDTH  = 29,
    parameter int Q          = 3329,
    parameter int QINV       = -3327,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] out_data,
    output logic                  out_range_err,
    output logic                  busy
);
    localparam logic signed [15:0] QS    = 16'(Q);
    localparam logic signed [15:0] QINVS = 16'(QINV);
    localparam int                 QB    = Q * 32768;
    logic signed [DIN_WIDTH-1:0] in_s;
    logic signed [31:0]          a_ext, u;
    logic signed [15:0]          a_lo;
    logic                        adv;
    logic                        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                        e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
    logic signed [31:0]          a1_q, a1_d, a2_q, a2_d;
    logic signed [15:0]          t1_q, t1_d;
    logic signed [28:0]          p2_q, p2_d;
    logic [DOUT_WIDTH-1:0]       d3_q, d3_d;
    // All stages move in lockstep; a stalled output freezes the whole pipe, gaps included.
    always_comb begin
        in_s  = in_data;
        a_ext = 32'(in_s);
        a_lo  = a_ext[15:0];
        u     = a2_q - 32'(p2_q);
        adv   = ~v3_q | out_ready;
        v1_d  = adv ? in_valid : v1_q;
        a1_d  = adv ? a_ext : a1_q;
        t1_d  = adv ? a_lo * QINVS : t1_q;
        e1_d  = adv ? (a_ext >= QB || a_ext <= -QB) : e1_q;
        v2_d  = adv ? v1_q : v2_q;
        a2_d  = adv ? a1_q : a2_q;
        p2_d  = adv ? 29'(t1_q) * 29'(QS) : p2_q;
        e2_d  = adv ? e1_q : e2_q;
        v3_d  = adv ? v2_q : v3_q;
        d3_d  = adv ? DOUT_WIDTH'(u >>> 16) : d3_q;
        e3_d  = adv ? e2_q : e3_q;
    end
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            e1_q <= 1'b0;
            e2_q <= 1'b0;
            e3_q <= 1'b0;
            a1_q <= '0;
            a2_q <= '0;
            t1_q <= '0;
            p2_q <= '0;
            d3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            e1_q <= e1_d;
            e2_q <= e2_d;
            e3_q <= e3_d;
            a1_q <= a1_d;
            a2_q <= a2_d;
            t1_q <= t1_d;
            p2_q <= p2_d;
            d3_q <= d3_d;
        end
    end
    assign in_ready      = adv;
    assign out_valid     = v3_q;
    assign out_data      = d3_q;
    assign out_range_err = e3_q;
    assign busy          = v1_q | v2_q | v3_q;
endmodule

// File: tb/tb_mlkem_top_mont_reduce_pipe.sv
// tb_mlkem_top_mont_reduce_pipe: directed and random checks of the Montgomery reducer against an arithmetic model
module tb_mlkem_top_mont_reduce_pipe;
    localparam int DW = 29;
    localparam int Q  = 3329;
    localparam int QINV = -3327;
    localparam int QB = Q * 32768;
    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_range_err, busy;
    logic [DW-1:0] in_data;
    logic [15:0]   out_data;
    int            vectors = 0, miscompares = 0;
    int            a_q[$];
    int            n_in = 0, n_out = 0, sent, a, n0;
    bit            acc;
    int            vec[5] = '{0, 65536, -1, 3329, -65536};
    int            rv[5]  = '{0, 1, -169, 0, -1};

    mlkem_top_mont_reduce_pipe #(.DIN_WIDTH(DW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_range_err(out_range_err), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic int ref_r(input int x);
        longint t;
        t = ((longint'(x) * QINV) % 65536 + 65536) % 65536;
        if (t >= 32768) t -= 65536;
        return int'((longint'(x) - t * Q) / 65536);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        int x, obs;
        bit e;
        if (a_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
            return;
        end
        x = a_q.pop_front();
        e = (x >= QB || x <= -QB);
        obs = int'($signed(out_data));
        n_out++;
        chk("out_data", obs, ref_r(x));
        chk("out_range_err", int'(out_range_err), int'(e));
        if (!e) chk("range_congruence", int'(obs > -Q && obs < Q && ((longint'(obs) * 65536 - x) % Q) == 0), 1);
    endtask

    task automatic step(input bit v, input int x, input bit rdy);
        in_valid = v;
        in_data = x[DW-1:0];
        out_ready = rdy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) pop_check();
        if (acc) begin
            a_q.push_back(x);
            n_in++;
        end
        @(negedge ap_clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && a_q.size() > 0; i++) step(0, 0, 1);
        chk("drain_empty", a_q.size(), 0);
        step(0, 0, 1);
        chk("drain_busy", int'(busy), 0);
        chk("drain_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        ap_rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_range_err", int'(out_range_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge ap_clk);
        step(1, 1, 1);
        chk("lat1_valid", int'(out_valid), 0);
        step(0, 0, 1);
        chk("lat2_valid", int'(out_valid), 0);
        step(0, 0, 1);
        chk("lat3_valid", int'(out_valid), 1);
        chk("lat3_data", int'($signed(out_data)), 169);
        chk("lat3_err", int'(out_range_err), 0);
        drain();
        for (int i = 0; i < 5; i++) begin
            step(1, vec[i], 1);
            chk("b2b_busy", int'(busy), 1);
            if (i >= 2) chk("b2b_data", int'($signed(out_data)), rv[i-2]);
        end
        for (int i = 3; i < 5; i++) begin
            step(0, 0, 1);
            chk("b2b_busy", int'(busy), 1);
            chk("b2b_data", int'($signed(out_data)), rv[i]);
        end
        drain();
        n0 = n_out;
        step(1, 11, 1);
        step(1, -22222, 1);
        step(1, 3333333, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 44, 0);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_out_data", int'($signed(out_data)), ref_r(a_q[0]));
        end
        step(1, 44, 1);
        step(1, -555555, 1);
        step(1, 66, 1);
        drain();
        chk("bp_count", n_out - n0, 6);
        step(1, 109084672, 1);
        step(1, 1, 1);
        step(1, -109084672, 1);
        drain();
        step(1, 5, 1);
        step(1, 6, 1);
        step(1, 7, 1);
        ap_rst = 1'b1;
        step(0, 0, 0);
        ap_rst = 1'b0;
        a_q.delete();
        #1;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_in_ready", int'(in_ready), 1);
        @(negedge ap_clk);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1);
            chk("mrst_idle_valid", int'(out_valid), 0);
        end
        n_in = 0;
        n_out = 0;
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            a = int'($urandom_range(0, 2 * QB - 2)) - (QB - 1);
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
            if (acc) sent++;
        end
        chk("rand_sent", sent, 10000);
        drain();
        chk("rand_in_out_count", n_out, n_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mlkem_top_mont_reduce_pipe.md
Name: mlkem_top_mont_reduce_pipe

Overview:
- Pipelined signed Montgomery reducer; the inverse-direction partner of the coefficient×constant multipliers (16s×13ns→29).
- Consumes a wide signed product and returns a 16-bit signed coefficient r ≡ a·2^-16 (mod Q), with r in (−Q, Q).
- Sits between the NTT/basemul multiplier outputs and the coefficient write-back path.
- Uses a valid/ready stream on both sides, with full backpressure.

Parameters:
- DIN_WIDTH, 29: signed input width. Legal range 17..32.
- Q, 3329: modulus, 12-bit unsigned.
- QINV, -3327: Q^-1 mod 2^16, interpreted as 16-bit signed.
- DOUT_WIDTH, 16: output width. Fixed at 16; any other value is illegal.

Ports:
- ap_clk, in, 1: clock. All state updates on the rising edge.
- ap_rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block can accept the input word.
- in_data, in, DIN_WIDTH: signed product a.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, DOUT_WIDTH: signed reduced coefficient r.
- out_range_err, out, 1: set when the input tied to this result had |a| ≥ Q·2^15.
- busy, out, 1: at least one pipeline stage holds a valid word.

Behaviour:
- Interface: one clock, ap_clk; reset is synchronous and active-high (ap_rst). All registers clear on a rising edge with ap_rst=1.
- Reset values:
  - out_valid=0, out_data=0, out_range_err=0, busy=0.
  - All stage valid bits = 0.
  - in_ready=1 in the first cycle after reset is released.
- Arithmetic, computed at 32-bit signed internally with in_data sign-extended:
  - S1: t = low16(a)·QINV; keep low 16 bits as signed int16. Register a, t and the range flag (|a| ≥ Q·2^15).
  - S2: p = t·Q as a 29-bit signed product. Register a, p and the flag.
  - S3: u = a − p. Low 16 bits of u are zero by construction. out_data = u[31:16]. Register into the output stage.
- Pipeline and handshake:
  - Three register stages, each with a valid bit.
  - Global enable adv = ~out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv, purely combinational from out_valid and out_ready.
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Latency and throughput:
  - Latency is exactly 3 cycles from accept to out_valid when out_ready stays high.
  - Throughput is 1 word per cycle.
  - Bubbles are not compressed: a stalled pipeline keeps its gaps.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- Stall: while out_valid=1 and out_ready=0, out_data and out_range_err are held stable and no stage advances. in_data is ignored.
- Ordering: results leave in input order.
- Out-of-range input:
  - The result is still computed and emitted.
  - out_range_err is asserted for that word only. It is not sticky.
  - The r ∈ (−Q, Q) guarantee does not apply to that word.
- Reset mid-operation: all in-flight words are discarded. No out_valid is produced for them after reset.
- busy = OR of the three stage valid bits.

Test Plan:
- Reset then a single word: after ap_rst, in_data=1 with out_ready=1 → out_data=169 exactly 3 cycles later; out_range_err=0.
- Known vectors streamed back-to-back: a = 0, 65536, −1, 3329, −65536 → r = 0, 1, −169, 0, −1 on consecutive cycles; busy=1 throughout.
- Backpressure: stream 6 words while holding out_ready=0 for 4 cycles after the first out_valid → in_ready=0 during the stall, out_data stable, all 6 results delivered in order, none duplicated or lost.
- Range flag: a = 3329·32768 = 109084672 (use DIN_WIDTH=29) → out_range_err=1 on that result only. Next word a=1 → err=0, r=169.
- Reset mid-stream: ap_rst pulsed 1 cycle while 3 words are in flight → out_valid stays 0 afterwards, busy=0, in_ready=1 the next cycle.
- Random regression: 10k random a with |a| < Q·2^15 against a reference model, with random in_valid/out_ready → r·2^16 ≡ a (mod Q), −Q < r < Q, order preserved.
